// File: rtl/ura_hazard_tracker_if.sv
// ura_hazard_tracker_if
// Groups the decode-side signals of the hazard tracker.
//   master : decode stage. It drives the issue, source query and MDU start signals
//            and receives stall, fwd_sel and md_busy.
//   slave  : the hazard tracker itself.
// Signals:
//   flush, issue_valid, issue_ura, issue_tnew : instruction entering stage 0
//   src_ura, src_tuse                         : decode-stage source queries
//   md_start, md_cycles                       : multiply/divide launch
//   stall, fwd_sel, md_busy                   : tracker results
interface ura_hazard_tracker_if #(
  parameter int STAGES    = 3,
  parameter int DST_PORTS = 3,
  parameter int SRC_PORTS = 2,
  parameter int TNEW_W    = 2,
  parameter int MD_BUSY_W = 4
);
  localparam int SEL_W = $clog2(STAGES + 1);

  logic                          flush;
  logic                          issue_valid;
  logic [DST_PORTS*7-1:0]        issue_ura;
  logic [TNEW_W-1:0]             issue_tnew;
  logic [SRC_PORTS*7-1:0]        src_ura;
  logic [SRC_PORTS*TNEW_W-1:0]   src_tuse;
  logic                          md_start;
  logic [MD_BUSY_W-1:0]          md_cycles;
  logic                          stall;
  logic [SRC_PORTS*SEL_W-1:0]    fwd_sel;
  logic                          md_busy;

  modport master (
    output flush, issue_valid, issue_ura, issue_tnew, src_ura, src_tuse,
           md_start, md_cycles,
    input  stall, fwd_sel, md_busy
  );

  modport slave (
    input  flush, issue_valid, issue_ura, issue_tnew, src_ura, src_tuse,
           md_start, md_cycles,
    output stall, fwd_sel, md_busy
  );
endinterface

// File: rtl/ura_hazard_tracker.sv
// ura_hazard_tracker
// Scoreboard of pending register writes (7-bit unified register addresses)
// held in the stages after decode. From it the block derives the decode stall,
// a per-source forwarding select and the multiply/divide busy state.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset. Clears valid bits, rem fields and
//           the MDU counter.
//   bus   : ura_hazard_tracker_if.slave. Carries the issue, source query and
//           MDU inputs, and the stall, fwd_sel and md_busy outputs.
module ura_hazard_tracker #(
  parameter int STAGES    = 3,
  parameter int DST_PORTS = 3,
  parameter int SRC_PORTS = 2,
  parameter int TNEW_W    = 2,
  parameter int MD_BUSY_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  ura_hazard_tracker_if.slave   bus
);
  localparam int URA_W = 7;
  localparam int SEL_W = $clog2(STAGES + 1);
  localparam logic [URA_W-1:0] URA_NONE = 7'b0000000;
  localparam logic [URA_W-1:0] URA_HI   = 7'b1000000;
  localparam logic [URA_W-1:0] URA_LO   = 7'b1000001;

  logic [STAGES-1:0]              valid_q, valid_d;
  logic [DST_PORTS*URA_W-1:0]     ura_q [STAGES];
  logic [DST_PORTS*URA_W-1:0]     ura_d [STAGES];
  logic [TNEW_W-1:0]              rem_q [STAGES];
  logic [TNEW_W-1:0]              rem_d [STAGES];
  logic [MD_BUSY_W-1:0]           md_cnt_q, md_cnt_d;

  logic                           src_stall;
  logic                           hilo_hit;
  logic                           mdu_active;
  logic                           stall_c;
  logic                           load_s0;
  logic                           found;
  logic [URA_W-1:0]               src;
  logic [TNEW_W-1:0]              tuse;
  logic [SRC_PORTS*SEL_W-1:0]     fwd_sel_c;

  function automatic logic is_hilo(input logic [URA_W-1:0] u);
    return (u == URA_HI) || (u == URA_LO);
  endfunction

  // URA zero is "no register" and never matches, on either side.
  function automatic logic stage_hit(input logic [DST_PORTS*URA_W-1:0] dsts,
                                     input logic [URA_W-1:0]           s);
    logic hit;
    hit = 1'b0;
    for (int p = 0; p < DST_PORTS; p++) begin
      if ((s != URA_NONE) && (dsts[p*URA_W +: URA_W] == s)) begin
        hit = 1'b1;
      end else begin
        hit = hit;
      end
    end
    return hit;
  endfunction

  function automatic logic [TNEW_W-1:0] sat_dec(input logic [TNEW_W-1:0] r);
    return (r == '0) ? '0 : r - TNEW_W'(1);
  endfunction

  // Hazard lookup: youngest matching stage per source, plus the HI/LO interlock.
  always_comb begin
    src_stall  = 1'b0;
    hilo_hit   = 1'b0;
    fwd_sel_c  = '0;
    found      = 1'b0;
    src        = URA_NONE;
    tuse       = '0;
    mdu_active = (md_cnt_q != '0) | bus.md_start;
    for (int s = 0; s < SRC_PORTS; s++) begin
      src   = bus.src_ura[s*URA_W +: URA_W];
      tuse  = bus.src_tuse[s*TNEW_W +: TNEW_W];
      found = 1'b0;
      // Scan from the youngest stage upward; the first hit masks older stages.
      for (int k = 0; k < STAGES; k++) begin
        if (!found && valid_q[k] && stage_hit(ura_q[k], src)) begin
          found = 1'b1;
          if (rem_q[k] > tuse) begin
            src_stall = 1'b1;
          end else begin
            src_stall = src_stall;
          end
          if (rem_q[k] == '0) begin
            fwd_sel_c[s*SEL_W +: SEL_W] = SEL_W'(k + 1);
          end else begin
            fwd_sel_c[s*SEL_W +: SEL_W] = '0;
          end
        end else begin
          found = found;
        end
      end
      if (is_hilo(src)) begin
        hilo_hit = 1'b1;
      end else begin
        hilo_hit = hilo_hit;
      end
    end
    for (int p = 0; p < DST_PORTS; p++) begin
      if (bus.issue_valid && is_hilo(bus.issue_ura[p*URA_W +: URA_W])) begin
        hilo_hit = 1'b1;
      end else begin
        hilo_hit = hilo_hit;
      end
    end
    stall_c = src_stall | (mdu_active & hilo_hit);
  end

  // Next-state: shift down one stage, load stage 0, advance the MDU counter.
  always_comb begin
    load_s0    = bus.issue_valid & ~stall_c & ~bus.flush;
    valid_d[0] = load_s0;
    ura_d[0]   = load_s0 ? bus.issue_ura  : '0;
    rem_d[0]   = load_s0 ? bus.issue_tnew : '0;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1] & ~bus.flush;
      ura_d[k]   = ura_q[k-1];
      rem_d[k]   = sat_dec(rem_q[k-1]);
    end
    // A restart while busy simply reloads; md_cycles of 0 leaves the MDU idle.
    if (bus.md_start) begin
      md_cnt_d = bus.md_cycles;
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_BUSY_W'(1);
    end else begin
      md_cnt_d = md_cnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= '0;
      md_cnt_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        ura_q[k] <= '0;
        rem_q[k] <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      md_cnt_q <= md_cnt_d;
      for (int k = 0; k < STAGES; k++) begin
        ura_q[k] <= ura_d[k];
        rem_q[k] <= rem_d[k];
      end
    end
  end

  assign bus.stall   = stall_c;
  assign bus.fwd_sel = fwd_sel_c;
  assign bus.md_busy = (md_cnt_q != '0);

endmodule

// File: tb/tb_ura_hazard_tracker.sv
// tb_ura_hazard_tracker
// Directed scenarios followed by randomized traffic. The DUT is checked every
// cycle against a behavioural scoreboard built from integer arrays.
module tb_ura_hazard_tracker;
  localparam int STAGES    = 3;
  localparam int DST_PORTS = 3;
  localparam int SRC_PORTS = 2;
  localparam int TNEW_W    = 2;
  localparam int MD_BUSY_W = 4;
  localparam int URA_W     = 7;
  localparam int SEL_W     = $clog2(STAGES + 1);
  localparam int HI        = 64;
  localparam int LO        = 65;

  logic clk;
  logic reset;

  ura_hazard_tracker_if #(
    .STAGES(STAGES), .DST_PORTS(DST_PORTS), .SRC_PORTS(SRC_PORTS),
    .TNEW_W(TNEW_W), .MD_BUSY_W(MD_BUSY_W)
  ) bus ();

  ura_hazard_tracker #(
    .STAGES(STAGES), .DST_PORTS(DST_PORTS), .SRC_PORTS(SRC_PORTS),
    .TNEW_W(TNEW_W), .MD_BUSY_W(MD_BUSY_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Scoreboard: one record per stage, youngest first.
  int m_valid [STAGES];
  int m_ura   [STAGES][DST_PORTS];
  int m_rem   [STAGES];
  int m_md;

  int exp_stall;
  int exp_fwd [SRC_PORTS];
  int exp_md;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_idle();
    bus.flush       = 1'b0;
    bus.issue_valid = 1'b0;
    bus.issue_ura   = '0;
    bus.issue_tnew  = '0;
    bus.src_ura     = '0;
    bus.src_tuse    = '0;
    bus.md_start    = 1'b0;
    bus.md_cycles   = '0;
  endtask

  task automatic set_src(input int s, input int ura, input int tuse);
    bus.src_ura[s*URA_W +: URA_W]    = URA_W'(ura);
    bus.src_tuse[s*TNEW_W +: TNEW_W] = TNEW_W'(tuse);
  endtask

  task automatic set_issue(input int u0, input int u1, input int u2, input int tnew);
    bus.issue_valid = 1'b1;
    bus.issue_ura   = {URA_W'(u2), URA_W'(u1), URA_W'(u0)};
    bus.issue_tnew  = TNEW_W'(tnew);
  endtask

  // Expected outputs from the current scoreboard and the present inputs.
  task automatic model_eval();
    int src, tuse, best, hilo, u;
    exp_stall = 0;
    hilo      = 0;
    for (int s = 0; s < SRC_PORTS; s++) begin
      src  = int'(bus.src_ura[s*URA_W +: URA_W]);
      tuse = int'(bus.src_tuse[s*TNEW_W +: TNEW_W]);
      exp_fwd[s] = 0;
      best = -1;
      for (int k = STAGES - 1; k >= 0; k--) begin
        for (int p = 0; p < DST_PORTS; p++) begin
          if (m_valid[k] != 0 && src != 0 && m_ura[k][p] == src) best = k;
        end
      end
      if (best >= 0) begin
        if (m_rem[best] > tuse) exp_stall = 1;
        if (m_rem[best] == 0) exp_fwd[s] = best + 1;
      end
      if (src == HI || src == LO) hilo = 1;
    end
    for (int p = 0; p < DST_PORTS; p++) begin
      u = int'(bus.issue_ura[p*URA_W +: URA_W]);
      if (bus.issue_valid && (u == HI || u == LO)) hilo = 1;
    end
    if ((m_md > 0 || bus.md_start) && hilo != 0) exp_stall = 1;
    exp_md = (m_md > 0) ? 1 : 0;
  endtask

  // Advance the scoreboard across one clock edge.
  task automatic model_update();
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        m_valid[k] = 0;
        m_rem[k]   = 0;
        for (int p = 0; p < DST_PORTS; p++) m_ura[k][p] = 0;
      end
      m_md = 0;
    end else begin
      for (int k = STAGES - 1; k >= 1; k--) begin
        m_valid[k] = bus.flush ? 0 : m_valid[k-1];
        m_rem[k]   = (m_rem[k-1] > 0) ? m_rem[k-1] - 1 : 0;
        for (int p = 0; p < DST_PORTS; p++) m_ura[k][p] = m_ura[k-1][p];
      end
      if (!bus.flush && bus.issue_valid && exp_stall == 0) begin
        m_valid[0] = 1;
        m_rem[0]   = int'(bus.issue_tnew);
        for (int p = 0; p < DST_PORTS; p++) m_ura[0][p] = int'(bus.issue_ura[p*URA_W +: URA_W]);
      end else begin
        m_valid[0] = 0;
      end
      if (bus.md_start) m_md = int'(bus.md_cycles);
      else if (m_md > 0) m_md = m_md - 1;
    end
  endtask

  task automatic step_eval();
    #1;
    model_eval();
    check_eq("stall", 32'(bus.stall), 32'(exp_stall));
    check_eq("md_busy", 32'(bus.md_busy), 32'(exp_md));
    for (int s = 0; s < SRC_PORTS; s++) begin
      check_eq($sformatf("fwd_sel[%0d]", s), 32'(bus.fwd_sel[s*SEL_W +: SEL_W]), 32'(exp_fwd[s]));
    end
  endtask

  task automatic step_clk();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cycle();
    step_eval();
    step_clk();
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  function automatic int rand_ura();
    int r;
    r = int'($urandom_range(0, 9));
    case (r)
      0:       return 0;
      7:       return HI;
      8:       return LO;
      9:       return 32 + 12;
      default: return (r % 4) + 1;
    endcase
  endfunction

  initial begin
    reset = 1'b1;
    drive_idle();
    for (int k = 0; k < STAGES; k++) begin
      m_valid[k] = 0;
      m_rem[k]   = 0;
      for (int p = 0; p < DST_PORTS; p++) m_ura[k][p] = 0;
    end
    m_md = 0;
    @(negedge clk);
    do_reset();

    // Idle after reset.
    step_eval();
    check_eq("rst_stall", 32'(bus.stall), 32'd0);
    check_eq("rst_fwd", 32'(bus.fwd_sel), 32'd0);
    check_eq("rst_md_busy", 32'(bus.md_busy), 32'd0);
    step_clk();

    // Load to URA 5 with tnew=2, consumer tuse=0.
    set_issue(5, 0, 0, 2);
    set_src(0, 5, 0);
    cycle();
    bus.issue_valid = 1'b0;
    step_eval();
    check_eq("load_stall1", 32'(bus.stall), 32'd1);
    step_clk();
    step_eval();
    check_eq("load_stall2", 32'(bus.stall), 32'd1);
    step_clk();
    step_eval();
    check_eq("load_nostall", 32'(bus.stall), 32'd0);
    check_eq("load_fwd", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd3);
    step_clk();

    // Two writers of $3: the youngest supplies the value.
    do_reset();
    set_issue(3, 0, 0, 1);
    cycle();
    set_issue(3, 0, 0, 0);
    cycle();
    bus.issue_valid = 1'b0;
    set_src(0, 3, 0);
    step_eval();
    check_eq("young_stall", 32'(bus.stall), 32'd0);
    check_eq("young_fwd", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd1);
    step_clk();

    // URA zero never matches.
    do_reset();
    set_issue(0, 0, 0, 3);
    cycle();
    bus.issue_valid = 1'b0;
    set_src(0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step_eval();
      check_eq("zero_stall", 32'(bus.stall), 32'd0);
      check_eq("zero_fwd", 32'(bus.fwd_sel[0 +: SEL_W]), 32'd0);
      step_clk();
    end

    // mult + mflo interlock over 5 busy cycles.
    do_reset();
    set_issue(HI, LO, 0, 0);
    bus.md_start  = 1'b1;
    bus.md_cycles = 4'd5;
    cycle();
    drive_idle();
    set_src(0, LO, 0);
    for (int i = 0; i < 5; i++) begin
      step_eval();
      check_eq("mdu_stall", 32'(bus.stall), 32'd1);
      check_eq("mdu_busy", 32'(bus.md_busy), 32'd1);
      step_clk();
    end
    step_eval();
    check_eq("mdu_release", 32'(bus.stall), 32'd0);
    check_eq("mdu_idle", 32'(bus.md_busy), 32'd0);
    step_clk();

    // Flush with a concurrent issue.
    do_reset();
    set_issue(7, 0, 0, 3);
    bus.md_start  = 1'b1;
    bus.md_cycles = 4'd9;
    cycle();
    bus.md_start = 1'b0;
    bus.flush    = 1'b1;
    set_src(0, 7, 0);
    cycle();
    drive_idle();
    set_src(0, 7, 0);
    step_eval();
    check_eq("flush_stall", 32'(bus.stall), 32'd0);
    check_eq("flush_md_busy", 32'(bus.md_busy), 32'd1);
    step_clk();

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset           = ($urandom_range(0, 63) == 0);
      bus.flush       = ($urandom_range(0, 31) == 0);
      bus.issue_valid = ($urandom_range(0, 2) != 0);
      bus.issue_ura   = {URA_W'(rand_ura()), URA_W'(rand_ura()), URA_W'(rand_ura())};
      bus.issue_tnew  = TNEW_W'($urandom_range(0, 3));
      for (int s = 0; s < SRC_PORTS; s++) set_src(s, rand_ura(), int'($urandom_range(0, 3)));
      bus.md_start    = ($urandom_range(0, 15) == 0);
      bus.md_cycles   = MD_BUSY_W'($urandom_range(0, 7));
      cycle();
    end
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
